// File: rtl/pc_redirect_pkg.sv
// Shared core package for the fetch/redirect path.
// Holds the EX-stage control-transfer op encodings, the branch-comparator
// op encodings that sit alongside them, the pc_redirect state encoding and
// a small alignment helper used by the target calculation.
package pc_redirect_pkg;

  // EX-stage control-transfer op (ex_op)
  localparam logic [1:0] EX_OP_NONE   = 2'b00;
  localparam logic [1:0] EX_OP_BRANCH = 2'b01;
  localparam logic [1:0] EX_OP_JAL    = 2'b10;
  localparam logic [1:0] EX_OP_JALR   = 2'b11;

  // Branch comparator op (funct3 style), consumed by the EX comparator
  localparam logic [2:0] BR_OP_EQ  = 3'b000;
  localparam logic [2:0] BR_OP_NE  = 3'b001;
  localparam logic [2:0] BR_OP_LT  = 3'b100;
  localparam logic [2:0] BR_OP_GE  = 3'b101;
  localparam logic [2:0] BR_OP_LTU = 3'b110;
  localparam logic [2:0] BR_OP_GEU = 3'b111;

  // pc_redirect state encoding
  localparam logic [1:0] ST_RESET_WAIT = 2'b00;
  localparam logic [1:0] ST_FETCH      = 2'b01;
  localparam logic [1:0] ST_PEND       = 2'b10;

  // Instruction fetch targets must be 4-byte aligned
  function automatic logic is_misaligned(input logic [63:0] addr);
    return addr[1:0] != 2'b00;
  endfunction

endpackage

// File: rtl/pc_redirect_branch_target.sv
// branch_target: combinational EX-stage redirect target calculation.
// Ports:
//   ex_valid_i  - EX instruction valid
//   ex_op_i     - control-transfer op (none/branch/jal/jalr)
//   br_taken_i  - branch comparator result
//   ex_pc_i     - EX pc
//   ex_imm_i    - sign-extended immediate
//   ex_rs1_i    - rs1 value (jalr base)
//   target_o    - redirect target
//   taken_o     - a control transfer is taken this cycle
//   misalign_o  - target bits [1:0] nonzero
module branch_target
  import pc_redirect_pkg::*;
(
  input  logic        ex_valid_i,
  input  logic [1:0]  ex_op_i,
  input  logic        br_taken_i,
  input  logic [63:0] ex_pc_i,
  input  logic [63:0] ex_imm_i,
  input  logic [63:0] ex_rs1_i,
  output logic [63:0] target_o,
  output logic        taken_o,
  output logic        misalign_o
);

  logic [63:0] pc_rel;
  logic [63:0] rs1_rel;

  always_comb begin
    pc_rel  = ex_pc_i + ex_imm_i;
    rs1_rel = ex_rs1_i + ex_imm_i;
    // jalr clears bit 0 only; bit 1 can still flag misalignment
    target_o   = (ex_op_i == EX_OP_JALR) ? {rs1_rel[63:1], 1'b0} : pc_rel;
    taken_o    = ex_valid_i &
                 ((ex_op_i == EX_OP_JAL) || (ex_op_i == EX_OP_JALR) ||
                  ((ex_op_i == EX_OP_BRANCH) && br_taken_i));
    misalign_o = is_misaligned(target_o);
  end

endmodule

// File: rtl/pc_redirect.sv
// pc_redirect: fetch pc sequencer with trap/EX redirect handling.
// Ports:
//   clk, rst        - clock, synchronous active-high reset
//   stall           - hold sequential fetch (ignored for redirects)
//   ex_valid, ex_op, br_taken, ex_pc, ex_imm, ex_rs1 - EX redirect source
//   trap_req, trap_pc - exception redirect (highest priority)
//   imem_ready      - instruction memory accepts if_pc
//   if_pc, if_valid - fetch request
//   flush_if_id, flush_id_ex - same-cycle pipeline kills on accepted redirect
//   misalign_exc    - pulse when a taken EX target is misaligned
module pc_redirect
  import pc_redirect_pkg::*;
#(
  parameter logic [63:0] RESET_PC = 64'h0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        ex_valid,
  input  logic [1:0]  ex_op,
  input  logic        br_taken,
  input  logic [63:0] ex_pc,
  input  logic [63:0] ex_imm,
  input  logic [63:0] ex_rs1,
  input  logic        trap_req,
  input  logic [63:0] trap_pc,
  input  logic        imem_ready,
  output logic [63:0] if_pc,
  output logic        if_valid,
  output logic        flush_if_id,
  output logic        flush_id_ex,
  output logic        misalign_exc
);

  logic [1:0]  state_q, state_d;
  logic [63:0] pc_q, pc_d;
  logic [63:0] pend_q, pend_d;

  logic [63:0] ex_target;
  logic        ex_taken;
  logic        ex_misalign;
  logic        ex_accept;
  logic        redirect;
  logic [63:0] redir_tgt;

  branch_target u_branch_target (
    .ex_valid_i (ex_valid),
    .ex_op_i    (ex_op),
    .br_taken_i (br_taken),
    .ex_pc_i    (ex_pc),
    .ex_imm_i   (ex_imm),
    .ex_rs1_i   (ex_rs1),
    .target_o   (ex_target),
    .taken_o    (ex_taken),
    .misalign_o (ex_misalign)
  );

  // A misaligned EX target is reported instead of followed; a trap in the
  // same cycle overrides both and the exception pulse is dropped.
  always_comb begin
    ex_accept    = ex_taken & ~ex_misalign;
    redirect     = trap_req | ex_accept;
    redir_tgt    = trap_req ? trap_pc : ex_target;
    flush_if_id  = redirect & ~rst;
    flush_id_ex  = redirect & ~rst;
    misalign_exc = ex_taken & ex_misalign & ~trap_req & ~rst;
    if_valid     = (state_q != ST_RESET_WAIT);
    if_pc        = pc_q;
  end

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    pend_d  = pend_q;
    case (state_q)
      ST_RESET_WAIT: begin
        // Nothing is presented yet, so a redirect can load pc directly
        state_d = ST_FETCH;
        if (redirect) pc_d = redir_tgt;
      end
      ST_FETCH: begin
        if (redirect) begin
          if (imem_ready) begin
            pc_d = redir_tgt;
          end else begin
            // Presented address must stay put until accepted
            pend_d  = redir_tgt;
            state_d = ST_PEND;
          end
        end else if (imem_ready && !stall) begin
          pc_d = pc_q + 64'd4;
        end
      end
      ST_PEND: begin
        if (redirect) begin
          // A newer redirect replaces the pending one
          if (imem_ready) begin
            pc_d    = redir_tgt;
            state_d = ST_FETCH;
          end else begin
            pend_d = redir_tgt;
          end
        end else if (imem_ready) begin
          pc_d    = pend_q;
          state_d = ST_FETCH;
        end
      end
      default: state_d = ST_RESET_WAIT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_RESET_WAIT;
      pc_q    <= RESET_PC;
      pend_q  <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      pend_q  <= pend_d;
    end
  end

endmodule

// File: tb/tb_pc_redirect.sv
module tb_pc_redirect;
  localparam logic [63:0] RPC = 64'h0;

  logic        clk = 1'b0;
  logic        rst;
  logic        stall;
  logic        ex_valid;
  logic [1:0]  ex_op;
  logic        br_taken;
  logic [63:0] ex_pc, ex_imm, ex_rs1;
  logic        trap_req;
  logic [63:0] trap_pc;
  logic        imem_ready;
  logic [63:0] if_pc;
  logic        if_valid;
  logic        flush_if_id, flush_id_ex, misalign_exc;

  pc_redirect #(.RESET_PC(RPC)) dut (
    .clk(clk), .rst(rst), .stall(stall), .ex_valid(ex_valid), .ex_op(ex_op),
    .br_taken(br_taken), .ex_pc(ex_pc), .ex_imm(ex_imm), .ex_rs1(ex_rs1),
    .trap_req(trap_req), .trap_pc(trap_pc), .imem_ready(imem_ready),
    .if_pc(if_pc), .if_valid(if_valid), .flush_if_id(flush_if_id),
    .flush_id_ex(flush_id_ex), .misalign_exc(misalign_exc)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [63:0] pc;
    logic        v;
    string       tag;
  } exp_t;
  exp_t sbq[$];

  typedef struct {
    string       name;
    logic        ex_valid;
    logic [1:0]  ex_op;
    logic        br_taken;
    logic [63:0] ex_pc, ex_imm, ex_rs1;
    logic        trap_req;
    logic [63:0] trap_pc;
    logic        stall, rdy;
    logic        e_flush, e_mis;
    logic [63:0] e_pc;
  } vec_t;

  function automatic vec_t mk(string n, logic v, logic [1:0] op, logic bt,
                              logic [63:0] pc, logic [63:0] imm, logic [63:0] rs1,
                              logic tr, logic [63:0] tpc, logic st, logic rdy,
                              logic ef, logic em, logic [63:0] epc);
    vec_t r;
    r.name = n; r.ex_valid = v; r.ex_op = op; r.br_taken = bt;
    r.ex_pc = pc; r.ex_imm = imm; r.ex_rs1 = rs1; r.trap_req = tr;
    r.trap_pc = tpc; r.stall = st; r.rdy = rdy;
    r.e_flush = ef; r.e_mis = em; r.e_pc = epc;
    return r;
  endfunction

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic idle();
    stall = 0; ex_valid = 0; ex_op = 2'b00; br_taken = 0;
    ex_pc = '0; ex_imm = '0; ex_rs1 = '0; trap_req = 0; trap_pc = '0;
    imem_ready = 1;
  endtask

  task automatic drive(vec_t t);
    ex_valid = t.ex_valid; ex_op = t.ex_op; br_taken = t.br_taken;
    ex_pc = t.ex_pc; ex_imm = t.ex_imm; ex_rs1 = t.ex_rs1;
    trap_req = t.trap_req; trap_pc = t.trap_pc; stall = t.stall;
    imem_ready = t.rdy;
  endtask

  // Inputs are already driven; push the expected post-edge fetch request,
  // check the combinational outputs mid-cycle, then pop after the edge.
  task automatic step(string tag, logic e_fl, logic e_mis, logic [63:0] e_pc, logic e_v);
    exp_t e;
    sbq.push_back('{pc: e_pc, v: e_v, tag: tag});
    @(negedge clk);
    chk({tag, "_flush_if_id"}, {63'd0, flush_if_id}, {63'd0, e_fl});
    chk({tag, "_flush_id_ex"}, {63'd0, flush_id_ex}, {63'd0, e_fl});
    chk({tag, "_misalign"}, {63'd0, misalign_exc}, {63'd0, e_mis});
    @(posedge clk); #1;
    if (sbq.size() == 0) begin
      checks++; errors++;
      $display("FAIL %s_scoreboard: got empty queue expected entry", tag);
    end else begin
      e = sbq.pop_front();
      chk({e.tag, "_if_pc"}, if_pc, e.pc);
      chk({e.tag, "_if_valid"}, {63'd0, if_valid}, {63'd0, e.v});
    end
  endtask

  // Reset then the RESET_WAIT cycle; leaves DUT in FETCH at RPC.
  task automatic do_reset();
    idle(); rst = 1;
    step("rst", 0, 0, RPC, 0);
    rst = 0;
    step("rwait", 0, 0, RPC, 1);
  endtask

  vec_t vt[16];

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    vt[0]  = mk("br_taken",      1, 2'b01, 1, 64'h100, 64'h20, 0, 0, 0, 0, 1, 1, 0, 64'h120);
    vt[1]  = mk("br_not_taken",  1, 2'b01, 0, 64'h100, 64'h20, 0, 0, 0, 0, 1, 0, 0, 64'h4);
    vt[2]  = mk("jal_invalid",   0, 2'b10, 0, 64'h100, 64'h20, 0, 0, 0, 0, 1, 0, 0, 64'h4);
    vt[3]  = mk("jal_neg_imm",   1, 2'b10, 0, 64'h1000, 64'hFFFF_FFFF_FFFF_FFF8, 0, 0, 0, 0, 1, 1, 0, 64'hFF8);
    vt[4]  = mk("jalr_misalign", 1, 2'b11, 0, 0, 0, 64'h203, 0, 0, 0, 1, 0, 1, 64'h4);
    vt[5]  = mk("jalr_clr_b0",   1, 2'b11, 0, 0, 64'h100, 64'h201, 0, 0, 0, 1, 1, 0, 64'h300);
    vt[6]  = mk("br_misalign",   1, 2'b01, 1, 64'h100, 64'h2, 0, 0, 0, 0, 1, 0, 1, 64'h4);
    vt[7]  = mk("trap_over_jal", 1, 2'b10, 0, 64'h200, 64'h100, 0, 1, 64'h800, 1, 1, 1, 0, 64'h800);
    vt[8]  = mk("stall_hold",    0, 2'b00, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0, 64'h0);
    vt[9]  = mk("ready_low",     0, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 64'h0);
    vt[10] = mk("jal_wrap",      1, 2'b10, 0, 64'hFFFF_FFFF_FFFF_FFF0, 64'h20, 0, 0, 0, 0, 1, 1, 0, 64'h10);
    vt[11] = mk("trap_over_mis", 1, 2'b11, 0, 0, 0, 64'h3, 1, 64'h900, 0, 1, 1, 0, 64'h900);
    vt[12] = mk("op_none",       1, 2'b00, 1, 64'h100, 64'h20, 0, 0, 0, 0, 1, 0, 0, 64'h4);
    vt[13] = mk("redir_stall",   1, 2'b10, 0, 64'h40, 64'h40, 0, 0, 0, 1, 1, 1, 0, 64'h80);
    vt[14] = mk("redir_rdy_low", 1, 2'b10, 0, 64'h300, 64'h100, 0, 0, 0, 0, 0, 1, 0, 64'h0);
    vt[15] = mk("jalr_wrap",     1, 2'b11, 0, 0, 64'h1, 64'hFFFF_FFFF_FFFF_FFFF, 0, 0, 0, 1, 1, 0, 64'h0);

    idle(); rst = 1;

    // Reset release and sequential fetch
    do_reset();
    step("seq4", 0, 0, 64'h4, 1);
    step("seq8", 0, 0, 64'h8, 1);

    for (int i = 0; i < 16; i++) begin
      do_reset();
      drive(vt[i]);
      step(vt[i].name, vt[i].e_flush, vt[i].e_mis, vt[i].e_pc, 1);
    end

    // Redirect while memory busy: held, then issued after acceptance
    do_reset();
    drive(vt[14]);
    step("pend_enter", 1, 0, 64'h0, 1);
    idle(); imem_ready = 0;
    step("pend_hold1", 0, 0, 64'h0, 1);
    step("pend_hold2", 0, 0, 64'h0, 1);
    imem_ready = 1;
    step("pend_issue", 0, 0, 64'h400, 1);
    step("pend_after", 0, 0, 64'h404, 1);

    // Newer trap in PEND replaces the pending target
    do_reset();
    drive(vt[14]);
    step("ovr_enter", 1, 0, 64'h0, 1);
    idle(); imem_ready = 0; trap_req = 1; trap_pc = 64'h800;
    step("ovr_trap", 1, 0, 64'h0, 1);
    idle();
    step("ovr_issue", 0, 0, 64'h800, 1);

    // Newer redirect in PEND with memory ready goes straight out
    do_reset();
    drive(vt[14]);
    step("ovr2_enter", 1, 0, 64'h0, 1);
    idle(); ex_valid = 1; ex_op = 2'b10; ex_pc = 64'h500; ex_imm = 64'h100;
    step("ovr2_jal", 1, 0, 64'h600, 1);
    idle();
    step("ovr2_next", 0, 0, 64'h604, 1);

    // Reset mid-PEND drops the pending target; flush masked during reset
    do_reset();
    drive(vt[14]);
    step("rpend_enter", 1, 0, 64'h0, 1);
    idle(); rst = 1; trap_req = 1; trap_pc = 64'hA00;
    step("rpend_rst", 0, 0, RPC, 0);
    idle(); rst = 0;
    step("rpend_wait", 0, 0, RPC, 1);
    step("rpend_s4", 0, 0, 64'h4, 1);
    step("rpend_s8", 0, 0, 64'h8, 1);

    // pc wrap at top of address space
    do_reset();
    trap_req = 1; trap_pc = 64'hFFFF_FFFF_FFFF_FFFC;
    step("wrap_trap", 1, 0, 64'hFFFF_FFFF_FFFF_FFFC, 1);
    idle();
    step("wrap_zero", 0, 0, 64'h0, 1);
    step("wrap_four", 0, 0, 64'h4, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
